hex2dec_sched: RTL and testbench

- Two-channel scheduler that shares one Hex2Dec converter between two requesters.
- Accepts a 16-bit binary value per channel through a valid/ready handshake and arbitrates round-robin.
- Loads the converter, waits for its done flag (with a watchdog), and returns the 4-digit BCD result tagged with the channel.
- Sits between the display/readout sources and the Hex2Dec instance.

---
 rtl/hex2dec_pkg.sv | 18 +
 rtl/rr_arb2.sv | 18 +
 rtl/hex2dec_sched.sv | 143 ++++++++++++++
 tb/tb_hex2dec_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex2dec_pkg.sv
// Shared constants and state encoding for the hex2dec scheduler.
package hex2dec_pkg;

  // Scheduler FSM state, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t WAIT = 2'd2;
  localparam state_t DONE = 2'd3;

  // Largest binary value the 4-digit BCD converter can represent.
  localparam logic [15:0] BCD_MAX = 16'd9999;
  // Result reported when the input does not fit in four digits.
  localparam logic [15:0] SAT_VAL = 16'h9999;
  // Result reported when the converter never answers.
  localparam logic [15:0] TMO_VAL = 16'h0000;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The pointer (last served channel) lives
// in the parent so it only advances when a grant is actually consumed.
module rr_arb2 (
  input  logic [1:0] pend,
  input  logic       last,
  output logic [1:0] gnt
);

  // Single requester wins outright; on a tie the channel not served last wins.
  always_comb begin
    // NOTE: assign a default first so every path drives gnt and no latch is inferred.
    gnt = pend;
    if (pend == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/hex2dec_sched.sv
// Two-channel scheduler sharing one Hex2Dec converter. Each channel hands
// over a binary value through valid/ready, a round-robin pick chooses the
// next one, and the BCD result comes back tagged with its channel. Inputs
// above 9999 are saturated locally; a hung converter is cut off by a
// watchdog.
module hex2dec_sched
  import hex2dec_pkg::*;
#(
  parameter int W       = 16,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         req0,
  input  logic [W-1:0] bin0,
  output logic         rdy0,
  input  logic         req1,
  input  logic [W-1:0] bin1,
  output logic         rdy1,
  output logic [W-1:0] res,
  output logic         res_ch,
  output logic         res_vld,
  output logic         res_ovf,
  output logic         res_tmo,
  output logic         busy,
  output logic         conv_ld,
  output logic [W-1:0] conv_i,
  input  logic         conv_done,
  input  logic [W-1:0] conv_o
);

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic          pend0, pend1;
  logic [W-1:0]  buf0, buf1;
  logic          last;
  logic          sel;
  logic [TW-1:0] timer;
  logic [1:0]    gnt;
  logic          cap0, cap1;
  logic          clr0, clr1;
  logic [W-1:0]  gnt_val;

  // Handshake and strobes are all qualified by ce so a frozen cycle emits nothing.
  assign rdy0    = ~pend0 & ce;
  assign rdy1    = ~pend1 & ce;
  assign cap0    = req0 & rdy0;
  assign cap1    = req1 & rdy1;
  assign busy    = (state != IDLE);
  assign conv_ld = ce & (state == LOAD);
  assign res_vld = ce & (state == DONE);

  // The served channel frees its slot as DONE completes.
  assign clr0 = (state == DONE) & ~sel;
  assign clr1 = (state == DONE) &  sel;

  // gnt[1] set means channel 1 was picked.
  assign gnt_val = gnt[1] ? buf1 : buf0;

  rr_arb2 u_arb (
    .pend ({pend1, pend0}),
    .last (last),
    .gnt  (gnt)
  );

  // Capture registers, arbitration pointer, FSM, watchdog and result latches.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (rst) begin
      // NOTE: the capture buffers are only two words, so they are reset along
      // with the control state rather than left holding stale data.
      state   <= IDLE;
      pend0   <= 1'b0;
      pend1   <= 1'b0;
      buf0    <= '0;
      buf1    <= '0;
      last    <= 1'b1;
      sel     <= 1'b0;
      timer   <= '0;
      res     <= '0;
      res_ch  <= 1'b0;
      res_ovf <= 1'b0;
      res_tmo <= 1'b0;
      conv_i  <= '0;
    end else if (ce) begin
      pend0 <= (pend0 & ~clr0) | cap0;
      pend1 <= (pend1 & ~clr1) | cap1;
      if (cap0) buf0 <= bin0;
      if (cap1) buf1 <= bin1;

      case (state)
        IDLE: begin
          if (|gnt) begin
            sel <= gnt[1];
            if (gnt_val > BCD_MAX) begin
              // Out of range: answer directly, the converter is never touched.
              res     <= SAT_VAL;
              res_ch  <= gnt[1];
              res_ovf <= 1'b1;
              res_tmo <= 1'b0;
              state   <= DONE;
            end else begin
              conv_i <= gnt_val;
              state  <= LOAD;
            end
          end
        end
        LOAD: begin
          // A done flag seen here belongs to the previous job and is ignored.
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (conv_done) begin
            // A completion wins over a watchdog expiry in the same cycle.
            res     <= conv_o;
            res_ch  <= sel;
            res_ovf <= 1'b0;
            res_tmo <= 1'b0;
            state   <= DONE;
          end else if (timer == TMO_LAST) begin
            res     <= TMO_VAL;
            res_ch  <= sel;
            res_ovf <= 1'b0;
            res_tmo <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          last  <= sel;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex2dec_sched.sv
// Self-checking bench for hex2dec_sched: directed scenarios followed by
// random traffic, checked against a transaction-level reference model.
module tb_hex2dec_sched;

  localparam int W       = 16;
  localparam int TIMEOUT = 16;
  localparam int TW      = 4;

  logic         clk = 1'b0;
  logic         rst, ce;
  logic         req0, req1, rdy0, rdy1;
  logic [W-1:0] bin0, bin1;
  logic [W-1:0] res, conv_i, conv_o;
  logic         res_ch, res_vld, res_ovf, res_tmo, busy, conv_ld, conv_done;

  always #5 clk = ~clk;

  hex2dec_sched #(.W(W), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .req0      (req0),
    .bin0      (bin0),
    .rdy0      (rdy0),
    .req1      (req1),
    .bin1      (bin1),
    .rdy1      (rdy1),
    .res       (res),
    .res_ch    (res_ch),
    .res_vld   (res_vld),
    .res_ovf   (res_ovf),
    .res_tmo   (res_tmo),
    .busy      (busy),
    .conv_ld   (conv_ld),
    .conv_i    (conv_i),
    .conv_done (conv_done),
    .conv_o    (conv_o)
  );

  typedef struct {
    bit          ch;
    logic [15:0] val;
    logic [15:0] res;
    bit          ovf;
    bit          tmo;
    int          cap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ld_edge = 0;
  int   ld_cnt = 0;
  int   last_lat = 0;
  int   lat_a = 0;
  bit   model_last = 1'b1;
  bit   hang = 1'b0;
  int   conv_lat = 5;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Posedge counter used to measure latencies in whole cycles.
  always @(posedge clk) cyc++;

  // Behavioural converter: counts conv_lat enabled cycles after a load, then
  // raises done and holds it until the next load. hang suppresses the answer.
  int          cnt;
  bit          cbusy;
  logic [15:0] cval;
  always @(posedge clk) begin
    if (rst) begin
      conv_done <= 1'b0;
      conv_o    <= '0;
      cbusy     <= 1'b0;
    end else if (ce) begin
      if (conv_ld) begin
        cbusy     <= !hang;
        cnt       <= conv_lat;
        cval      <= conv_i;
        conv_done <= 1'b0;
      end else if (cbusy) begin
        if (cnt <= 1) begin
          conv_done <= 1'b1;
          conv_o    <= to_bcd(int'(cval));
          cbusy     <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // Monitor: results must come out in model order with the modelled contents.
  always @(negedge clk) begin
    if (conv_ld) begin
      ld_cnt++;
      ld_edge = cyc + 1;
      if (exp_q.size() > 0) check("conv_i", conv_i, exp_q[0].val);
    end
    if (res_vld) begin
      if (exp_q.size() == 0) begin
        check("spurious_vld", res_vld, 0);
      end else begin
        mon_e    = exp_q.pop_front();
        last_lat = cyc + 1 - mon_e.cap;
        check("result", {res_ch, res_ovf, res_tmo, res},
              {mon_e.ch, mon_e.ovf, mon_e.tmo, mon_e.res});
        if (mon_e.ovf) check("ovf_latency", last_lat, 2);
        // TIMEOUT wait cycles after LOAD, then the DONE cycle.
        if (mon_e.tmo) check("tmo_latency", cyc + 1 - ld_edge, TIMEOUT + 1);
      end
    end
  end

  function automatic exp_t model(input bit ch, input logic [15:0] v, input int cap);
    exp_t e;
    e.ch  = ch;
    e.val = v;
    e.cap = cap;
    e.ovf = (v > 16'd9999);
    e.tmo = !e.ovf && hang;
    e.res = e.ovf ? 16'h9999 : (e.tmo ? 16'h0000 : to_bcd(int'(v)));
    return e;
  endfunction

  // Present one or both requests for a single cycle; the model orders them.
  task automatic send(input bit r0, input logic [15:0] v0, input bit r1, input logic [15:0] v1);
    @(negedge clk);
    if (r0) check("rdy0_free", rdy0, 1);
    if (r1) check("rdy1_free", rdy1, 1);
    if (r0 && r1) begin
      if (model_last) begin
        exp_q.push_back(model(1'b0, v0, cyc + 1));
        exp_q.push_back(model(1'b1, v1, cyc + 1));
        model_last = 1'b1;
      end else begin
        exp_q.push_back(model(1'b1, v1, cyc + 1));
        exp_q.push_back(model(1'b0, v0, cyc + 1));
        model_last = 1'b0;
      end
    end else if (r0) begin
      exp_q.push_back(model(1'b0, v0, cyc + 1));
      model_last = 1'b0;
    end else if (r1) begin
      exp_q.push_back(model(1'b1, v1, cyc + 1));
      model_last = 1'b1;
    end
    req0 = r0; bin0 = v0;
    req1 = r1; bin1 = v1;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      check("idle_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1;
    req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {res, res_ch, res_vld, res_ovf, res_tmo, busy, conv_ld, conv_i}, 0);
    check("rst_rdy", {rdy0, rdy1}, 2'b11);
    rst = 1'b0;

    // Single conversions on each channel.
    ld_cnt = 0;
    send(1, 16'h0001, 0, 0); wait_idle();
    check("t1_res", {res_ch, res}, {1'b0, 16'h0001});
    check("t1_ld_cnt", ld_cnt, 1);
    send(0, 0, 1, 16'h00FF); wait_idle();
    check("t2_res", {res_ch, res}, {1'b1, 16'h0255});
    send(0, 0, 1, 16'h00AA); wait_idle();
    check("t3_res", {res_ch, res}, {1'b1, 16'h0170});

    // Simultaneous capture: ch1 was served last, so ch0 goes first.
    send(1, 16'h000A, 1, 16'h0063); wait_idle();
    check("both_a_last", {res_ch, res}, {1'b1, 16'h0099});

    // Overflow bypasses the converter; leaves ch0 as last served.
    ld_cnt = 0;
    send(1, 16'h2710, 0, 0); wait_idle();
    check("ovf_res", {res_ovf, res}, {1'b1, 16'h9999});
    check("ovf_no_ld", ld_cnt, 0);

    // Simultaneous again: now ch1 goes first.
    send(1, 16'h000A, 1, 16'h0063); wait_idle();
    check("both_b_last", {res_ch, res}, {1'b0, 16'h0010});

    send(1, 16'h270F, 0, 0); wait_idle();
    check("max_res", {res_ovf, res}, {1'b0, 16'h9999});

    // Converter never answers: watchdog fires, then normal service resumes.
    hang = 1'b1;
    send(0, 0, 1, 16'h1234); wait_idle();
    check("tmo_res", {res_tmo, res}, {1'b1, 16'h0000});
    hang = 1'b0;
    send(1, 16'h0042, 0, 0); wait_idle();
    check("post_tmo", {res_tmo, res}, {1'b0, 16'h0066});

    // ce low for 10 cycles mid-WAIT delays the result by exactly 10 cycles.
    conv_lat = 8;
    send(1, 16'd500, 0, 0); wait_idle();
    lat_a = last_lat;
    send(1, 16'd500, 0, 0);
    repeat (4) @(negedge clk);
    ce = 1'b0;
    #1;
    check("ce_low_quiet", {rdy0, rdy1, conv_ld, res_vld}, 0);
    repeat (10) @(negedge clk);
    ce = 1'b1;
    wait_idle();
    check("ce_delay", last_lat - lat_a, 10);

    // Reset in WAIT abandons the job silently.
    hang = 1'b1;
    send(1, 16'h0123, 0, 0);
    repeat (6) @(negedge clk);
    check("rst_busy_before", busy, 1);
    rst = 1'b1;
    exp_q.delete();
    model_last = 1'b1;
    @(negedge clk);
    check("rst_wait_outs", {res, res_ch, res_vld, res_ovf, res_tmo, busy, conv_ld, conv_i}, 0);
    check("rst_wait_rdy", {rdy0, rdy1}, 2'b11);
    rst = 1'b0;
    hang = 1'b0;
    repeat (20) @(negedge clk);

    // Random traffic.
    repeat (30) begin
      int mode;
      logic [15:0] v0, v1;
      mode     = $urandom_range(0, 2);
      conv_lat = $urandom_range(1, 6);
      v0 = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(10000, 65535)) : 16'($urandom_range(0, 9999));
      v1 = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(10000, 65535)) : 16'($urandom_range(0, 9999));
      send(mode != 1, v0, mode != 0, v1);
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
